// File: rtl/mem_reader_pkg.sv
// mem_reader_pkg: shared types and helpers for the mem_reader read sequencer.
package mem_reader_pkg;

  // Sequencer states; encodings kept identical to the original localparams.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Word-count width: must hold 0..2**addr_w inclusive.
  function automatic int unsigned cnt_w(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/mem_reader_if.sv
// mem_reader_if: memory read port plus valid/ready output stream.
// master = the sequencer, slave = memory array / downstream consumer side.
interface mem_reader_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mem_re, mem_addr, out_data, out_valid,
    input  mem_rdata, out_ready
  );

  modport slave (
    input  mem_re, mem_addr, out_data, out_valid,
    output mem_rdata, out_ready
  );
endinterface

// File: rtl/mem_reader_data_hold_reg.sv
// data_hold_reg: load-enable data register, synchronous active-low reset.
// Read-side counterpart of the store-enable register; holds the stream word.
module data_hold_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_q;

  // Capture i_d when load is asserted, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n)      r_q <= '0;
    else if (i_load) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/mem_reader.sv
// mem_reader: fetches COUNT consecutive words from BASE_ADDR (wrapping) and
// presents them one at a time on a valid/ready stream; one word in flight.
// Optional macro MEM_READER_ABORT_EN adds an 'abort' input that returns the
// sequencer to IDLE from any busy state without a done pulse.
module mem_reader
  import mem_reader_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [cnt_w(ADDR_W)-1:0]   count,
`ifdef MEM_READER_ABORT_EN
  input  logic                       abort,
`endif
  output logic                       busy,
  output logic                       done,
  mem_reader_if.master               bus
);

  localparam int unsigned CW = cnt_w(ADDR_W);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [CW-1:0]     r_rem, w_rem_nxt;
  logic              r_done, w_done_nxt;
  logic              w_load;
  logic              w_abort;

`ifdef MEM_READER_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // State and burst bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_mem_addr <= '0;
      r_rem      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_rem      <= w_rem_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Next-state and datapath control.
  // r_mem_addr is a separate copy of r_addr, only updated on entry to ISSUE,
  // so the memory address holds steady after the final increment.
  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_mem_addr_nxt = r_mem_addr;
    w_rem_nxt      = r_rem;
    w_done_nxt     = 1'b0;
    w_load         = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (count != '0) begin
            w_addr_nxt     = base_addr;
            w_mem_addr_nxt = base_addr;
            w_rem_nxt      = count;
            w_state_nxt    = ST_ISSUE;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        w_load      = 1'b1;
        w_state_nxt = ST_OUT;
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          w_addr_nxt = r_addr + 1'b1;
          w_rem_nxt  = r_rem - 1'b1;
          if (r_rem == CW'(1)) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_mem_addr_nxt = r_addr + 1'b1;
            w_state_nxt    = ST_ISSUE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_abort && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_done_nxt  = 1'b0;
      w_load      = 1'b0;
    end
  end

  data_hold_reg #(.DATA_W(DATA_W)) u_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_d    (bus.mem_rdata),
    .o_q    (bus.out_data)
  );

  assign bus.mem_re    = (r_state == ST_ISSUE);
  assign bus.mem_addr  = r_mem_addr;
  assign bus.out_valid = (r_state == ST_OUT);
  assign busy          = (r_state != ST_IDLE);
  assign done          = r_done;

endmodule

// File: tb/tb_mem_reader.sv
// tb_mem_reader: randomized self-checking bench for mem_reader against a
// burst-level reference (word i of a burst = mem[(base+i) mod depth]).
module tb_mem_reader;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int CW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] count = '0;
`ifdef MEM_READER_ABORT_EN
  logic          abort = 1'b0;
`endif
  logic          busy, done;

  mem_reader_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

  mem_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
`ifdef MEM_READER_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Memory array model: read data valid exactly one cycle after mem_re.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];

  int n_vec = 0;
  int n_err = 0;

  // Observations of the most recent burst.
  int q_addr[$];
  int q_data[$];
  int first_valid_k, done_k, done_cnt, last_hs_k, stall_bad, overlap_bad;
  bit timed_out, busy_seen;

  // Drive one start command and record what the DUT does, cycle by cycle.
  // k = number of clock edges since the edge that sampled start.
  task automatic run_burst(input int base, input int cnt, input int stall_idx,
                           input int stall_len, input bit rand_ready, input bit poke_start);
    int k = 0;
    int hs = 0;
    int stalled = 0;
    bit fin = 1'b0;
    logic [DW-1:0] held = '0;
    q_addr.delete(); q_data.delete();
    first_valid_k = -1; done_k = -1; done_cnt = 0; last_hs_k = -1;
    stall_bad = 0; overlap_bad = 0; timed_out = 1'b0; busy_seen = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = AW'(base); count = CW'(cnt);
    while (!fin && k < 400) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      if (poke_start && k == 4) begin
        start = 1'b1; base_addr = AW'(9); count = CW'(7);
      end
      if (hs == stall_idx && stalled > 0 && stalled < stall_len &&
          (!bus.out_valid || bus.out_data !== held || bus.mem_re))
        stall_bad++;
      if (bus.out_valid && hs == stall_idx && stalled < stall_len) begin
        if (stalled == 0) held = bus.out_data;
        bus.out_ready = 1'b0;
        stalled++;
      end else if (rand_ready) begin
        bus.out_ready = 1'($urandom_range(0, 1));
      end else begin
        bus.out_ready = 1'b1;
      end
      busy_seen |= busy;
      if (bus.out_valid && first_valid_k < 0) first_valid_k = k;
      if (bus.mem_re) q_addr.push_back(int'(bus.mem_addr));
      if (bus.out_valid && bus.out_ready) begin
        q_data.push_back(int'(bus.out_data));
        hs++;
        last_hs_k = k;
      end
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (done && busy) overlap_bad++;
      if (done_k > 0 && k >= done_k + 3) fin = 1'b1;
    end
    timed_out = !fin;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int hs = 0;
    bit hit = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, bus.mem_re, bus.mem_addr, bus.out_data, bus.out_valid} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b done=%b re=%b addr=%0d data=%0d valid=%b required all 0",
               busy, done, bus.mem_re, bus.mem_addr, bus.out_data, bus.out_valid);
    end
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1; base_addr = AW'(2); count = CW'(5); bus.out_ready = 1'b1;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus.out_valid && hs == 1) begin
        rst_n = 1'b0;
        hit = 1'b1;
      end else if (bus.out_valid && bus.out_ready) hs++;
    end
    n_vec++;
    if (!hit) begin
      n_err++;
      $display("FAIL reset_mid_reach: second OUT never reached, required reached");
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b0;
    n_vec++;
    if ({busy, done, bus.mem_re, bus.mem_addr, bus.out_data, bus.out_valid} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_state: got busy=%b done=%b re=%b addr=%0d data=%0d valid=%b required all 0",
               busy, done, bus.mem_re, bus.mem_addr, bus.out_data, bus.out_valid);
    end
    hit = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy || bus.out_valid || bus.mem_re) hit = 1'b1;
    end
    n_vec++;
    if (hit) begin
      n_err++;
      $display("FAIL reset_mid_quiet: got activity after reset, required idle with no done");
    end
  endtask

  task automatic test_basic();
    run_burst(3, 3, -1, 0, 1'b0, 1'b0);
    n_vec++;
    if (q_addr.size() != 3 || q_data.size() != 3) begin
      n_err++;
      $display("FAIL basic_len: got addr=%0d data=%0d required 3", q_addr.size(), q_data.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (i >= q_addr.size() || i >= q_data.size() ||
          q_addr[i] !== 3 + i || q_data[i] !== int'(mem[3 + i])) begin
        n_err++;
        $display("FAIL basic_word%0d: got addr=%0d data=%0d required addr=%0d data=%0d",
                 i, (i < q_addr.size()) ? q_addr[i] : -1, (i < q_data.size()) ? q_data[i] : -1,
                 3 + i, mem[3 + i]);
      end
    end
    n_vec++;
    if (first_valid_k !== 3) begin
      n_err++;
      $display("FAIL basic_latency: got %0d required 3", first_valid_k);
    end
    n_vec++;
    if (done_k !== 10 || done_cnt !== 1 || overlap_bad !== 0 || timed_out) begin
      n_err++;
      $display("FAIL basic_done: got at=%0d pulses=%0d overlap=%0d timeout=%0d required at=10 pulses=1 overlap=0 timeout=0",
               done_k, done_cnt, overlap_bad, timed_out);
    end
  endtask

  task automatic test_wrap();
    run_burst(14, 4, -1, 0, 1'b0, 1'b0);
    n_vec++;
    if (q_addr.size() != 4 || q_data.size() != 4 || done_k !== 13 || done_cnt !== 1) begin
      n_err++;
      $display("FAIL wrap_shape: got addr=%0d data=%0d done_at=%0d pulses=%0d required 4 4 13 1",
               q_addr.size(), q_data.size(), done_k, done_cnt);
    end
    for (int i = 0; i < 4 && i < q_addr.size() && i < q_data.size(); i++) begin
      n_vec++;
      if (q_addr[i] !== (14 + i) % DEPTH || q_data[i] !== int'(mem[(14 + i) % DEPTH])) begin
        n_err++;
        $display("FAIL wrap_word%0d: got addr=%0d data=%0d required addr=%0d data=%0d",
                 i, q_addr[i], q_data[i], (14 + i) % DEPTH, mem[(14 + i) % DEPTH]);
      end
    end
  endtask

  task automatic test_backpressure();
    run_burst(5, 4, 1, 5, 1'b0, 1'b0);
    n_vec++;
    if (stall_bad !== 0) begin
      n_err++;
      $display("FAIL bp_stable: got %0d unstable cycles required 0", stall_bad);
    end
    n_vec++;
    if (q_addr.size() != 4 || q_data.size() != 4 || done_k !== 18 || done_cnt !== 1) begin
      n_err++;
      $display("FAIL bp_shape: got addr=%0d data=%0d done_at=%0d pulses=%0d required 4 4 18 1",
               q_addr.size(), q_data.size(), done_k, done_cnt);
    end
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      n_vec++;
      if (q_data[i] !== int'(mem[5 + i])) begin
        n_err++;
        $display("FAIL bp_word%0d: got %0d required %0d", i, q_data[i], mem[5 + i]);
      end
    end
  endtask

  task automatic test_edge_cmds();
    int b;
    run_burst(7, 0, -1, 0, 1'b0, 1'b0);
    n_vec++;
    if (q_addr.size() != 0 || q_data.size() != 0 || done_k !== 1 || done_cnt !== 1 || busy_seen) begin
      n_err++;
      $display("FAIL count0: got reads=%0d words=%0d done_at=%0d pulses=%0d busy=%0d required 0 0 1 1 0",
               q_addr.size(), q_data.size(), done_k, done_cnt, busy_seen);
    end
    run_burst(0, 2, -1, 0, 1'b0, 1'b1);
    n_vec++;
    if (q_addr.size() != 2 || q_data.size() != 2 || done_k !== 7 || done_cnt !== 1 ||
        q_data[0] !== int'(mem[0]) || q_data[1] !== int'(mem[1])) begin
      n_err++;
      $display("FAIL start_busy: got reads=%0d words=%0d done_at=%0d pulses=%0d required 2 2 7 1",
               q_addr.size(), q_data.size(), done_k, done_cnt);
    end
    b = $urandom_range(0, DEPTH - 1);
    run_burst(b, 16, -1, 0, 1'b0, 1'b0);
    n_vec++;
    if (q_data.size() != 16 || done_k !== 49 || done_cnt !== 1) begin
      n_err++;
      $display("FAIL full_shape: got words=%0d done_at=%0d pulses=%0d required 16 49 1",
               q_data.size(), done_k, done_cnt);
    end
    for (int i = 0; i < 16 && i < q_data.size() && i < q_addr.size(); i++) begin
      n_vec++;
      if (q_addr[i] !== (b + i) % DEPTH || q_data[i] !== int'(mem[(b + i) % DEPTH])) begin
        n_err++;
        $display("FAIL full_word%0d: got addr=%0d data=%0d required addr=%0d data=%0d",
                 i, q_addr[i], q_data[i], (b + i) % DEPTH, mem[(b + i) % DEPTH]);
      end
    end
  endtask

  task automatic test_random();
    int b, c;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    for (int t = 0; t < 6; t++) begin
      b = $urandom_range(0, DEPTH - 1);
      c = $urandom_range(1, DEPTH);
      run_burst(b, c, -1, 0, 1'b1, 1'b0);
      n_vec++;
      if (q_data.size() != c || q_addr.size() != c || done_cnt !== 1 || overlap_bad !== 0 ||
          done_k !== last_hs_k + 1 || timed_out) begin
        n_err++;
        $display("FAIL rand%0d_shape: got words=%0d reads=%0d pulses=%0d done_at=%0d last_hs=%0d required %0d words, 1 pulse right after last handshake",
                 t, q_data.size(), q_addr.size(), done_cnt, done_k, last_hs_k, c);
      end
      for (int i = 0; i < c && i < q_data.size() && i < q_addr.size(); i++) begin
        n_vec++;
        if (q_addr[i] !== (b + i) % DEPTH || q_data[i] !== int'(mem[(b + i) % DEPTH])) begin
          n_err++;
          $display("FAIL rand%0d_word%0d: got addr=%0d data=%0d required addr=%0d data=%0d",
                   t, i, q_addr[i], q_data[i], (b + i) % DEPTH, mem[(b + i) % DEPTH]);
        end
      end
    end
  endtask

`ifdef MEM_READER_ABORT_EN
  task automatic test_abort();
    int hs = 0;
    bit prev_re = 1'b0;
    bit hit = 1'b0;
    bit noisy = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = AW'(4); count = CW'(5); bus.out_ready = 1'b1;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (hs == 1 && prev_re) begin
        abort = 1'b1;
        hit = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) hs++;
      prev_re = bus.mem_re;
    end
    @(negedge clk);
    abort = 1'b0;
    bus.out_ready = 1'b0;
    n_vec++;
    if (!hit || busy || bus.out_valid || bus.mem_re || done) begin
      n_err++;
      $display("FAIL abort_idle: got reached=%0d busy=%b valid=%b re=%b done=%b required 1 0 0 0 0",
               hit, busy, bus.out_valid, bus.mem_re, done);
    end
    repeat (4) begin
      @(negedge clk);
      if (done || busy || bus.mem_re) noisy = 1'b1;
    end
    n_vec++;
    if (noisy) begin
      n_err++;
      $display("FAIL abort_quiet: got activity after abort, required idle with no done");
    end
    run_burst(4, 2, -1, 0, 1'b0, 1'b0);
    n_vec++;
    if (q_data.size() != 2 || done_k !== 7 || done_cnt !== 1 ||
        q_data[0] !== int'(mem[4]) || q_data[1] !== int'(mem[5])) begin
      n_err++;
      $display("FAIL abort_restart: got words=%0d done_at=%0d pulses=%0d required 2 7 1",
               q_data.size(), done_k, done_cnt);
    end
  endtask
`endif

  initial begin
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 10);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_edge_cmds();
    test_random();
`ifdef MEM_READER_ABORT_EN
    test_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation timeout, required completion");
    $fatal(1, "timeout");
  end

endmodule
